// File: rtl/mem_pkg.sv
// Shared memory-bus definitions: command codes, I/O addresses, responder states.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package mem_pkg;

    // One-hot bus commands, shared with the CPU side.
    localparam logic [2:0] MNONE  = 3'b001;
    localparam logic [2:0] MREAD  = 3'b010;
    localparam logic [2:0] MWRITE = 3'b100;

    // Memory-mapped I/O word addresses.
    localparam int unsigned LED_ADDR = 'h100;
    localparam int unsigned SW_ADDR  = 'h140;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } resp_state_t;

    // True only for the two command codes that start an access.
    function automatic logic cmd_is_access(input logic [2:0] c);
        return (c == MREAD) || (c == MWRITE);
    endfunction

endpackage

// File: rtl/ram_sp.sv
// Synchronous single-port RAM with registered read data.
// Latency: 1 cycle; rdata updates on the edge of an enabled read, then holds.
// Backpressure: none; one access per enabled cycle, write has priority over read.
// Ports: clk, en (access enable), we (write when enabled), addr, wdata, rdata (registered).
module ram_sp #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 256,
    parameter int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Contents are intentionally not reset; they are undefined until written.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/vDFFE.sv
// Enable register with asynchronous active-high clear.
// Latency: 1 cycle from in to out when en is high.
// Backpressure: none; holds its value while en is low.
// Ports: clk, reset (async clear), en (load enable), in (next value), out (stored value).
module vDFFE #(
    parameter int n = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic [n-1:0] in,
    output logic [n-1:0] out
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out <= '0;
        end else if (en) begin
            out <= in;
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Memory-bus responder: RAM plus LED/switch I/O words behind a one-hot command bus.
// Latency: mem_ready pulses WAIT_CYCLES+1 cycles after the accept edge; next accept WAIT_CYCLES+2 later.
// Backpressure: bus ignored outside IDLE; a command still held on return to IDLE is re-accepted.
// Ports: clk, reset (async, active-high), mem_cmd/mem_addr/write_data (request),
//        sw_in (async switches), read_data/mem_ready/mem_err (response), led_out (LED register).
module mem_responder
    import mem_pkg::*;
#(
    parameter int ADDR_W      = 9,
    parameter int DATA_W      = 16,
    parameter int RAM_WORDS   = 256,
    parameter int WAIT_CYCLES = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [2:0]        mem_cmd,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] write_data,
    input  logic [7:0]        sw_in,
    output logic [DATA_W-1:0] read_data,
    output logic              mem_ready,
    output logic              mem_err,
    output logic [7:0]        led_out
);

    localparam int              RAM_AW    = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
    localparam bit              NO_WAIT   = (WAIT_CYCLES == 0);
    localparam logic [3:0]      WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
    localparam logic [ADDR_W:0] RAM_LIM   = (ADDR_W + 1)'(RAM_WORDS);
    localparam logic [ADDR_W-1:0] LED_A   = ADDR_W'(LED_ADDR);
    localparam logic [ADDR_W-1:0] SW_A    = ADDR_W'(SW_ADDR);

    resp_state_t       state;
    logic [3:0]        wait_cnt;
    logic [2:0]        lat_cmd;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic [7:0]        sw_meta, sw_sync;
    logic [DATA_W-1:0] ram_q, io_q;
    logic              rd_from_ram;

    logic              accept;
    logic              acc_go, acc_rd, acc_wr;
    logic [2:0]        acc_cmd;
    logic [ADDR_W-1:0] acc_addr;
    logic [DATA_W-1:0] acc_wdata;
    logic              hit_ram, hit_led, hit_sw, unmapped;

    assign accept = (state == ST_IDLE) && cmd_is_access(mem_cmd);

    // With no wait states the access happens on the accept edge itself, before the
    // latches hold anything, so the live bus is used in IDLE and the latched copy after.
    assign acc_cmd   = (state == ST_IDLE) ? mem_cmd    : lat_cmd;
    assign acc_addr  = (state == ST_IDLE) ? mem_addr   : lat_addr;
    assign acc_wdata = (state == ST_IDLE) ? write_data : lat_wdata;

    // acc_go marks the edge entering RESP: the one edge that commits the access.
    assign acc_go = (NO_WAIT && accept) || ((state == ST_WAIT) && (wait_cnt == 4'd0));
    assign acc_rd = acc_go && (acc_cmd == MREAD);
    assign acc_wr = acc_go && (acc_cmd == MWRITE);

    // No aliasing: RAM decodes only below RAM_WORDS, everything else is exact-match.
    assign hit_ram  = ({1'b0, acc_addr} < RAM_LIM);
    assign hit_led  = !hit_ram && (acc_addr == LED_A);
    assign hit_sw   = !hit_ram && (acc_addr == SW_A);
    assign unmapped = !(hit_ram || hit_led || hit_sw);

    vDFFE #(.n(3))      u_lat_cmd   (.clk(clk), .reset(reset), .en(accept), .in(mem_cmd),    .out(lat_cmd));
    vDFFE #(.n(ADDR_W)) u_lat_addr  (.clk(clk), .reset(reset), .en(accept), .in(mem_addr),   .out(lat_addr));
    vDFFE #(.n(DATA_W)) u_lat_wdata (.clk(clk), .reset(reset), .en(accept), .in(write_data), .out(lat_wdata));

    vDFFE #(.n(8)) u_led (
        .clk   (clk),
        .reset (reset),
        .en    (acc_wr && hit_led),
        .in    (acc_wdata[7:0]),
        .out   (led_out)
    );

    ram_sp #(
        .DATA_W (DATA_W),
        .DEPTH  (RAM_WORDS),
        .AW     (RAM_AW)
    ) u_ram (
        .clk   (clk),
        .en    (acc_go && hit_ram),
        .we    (acc_wr),
        .addr  (acc_addr[RAM_AW-1:0]),
        .wdata (acc_wdata),
        .rdata (ram_q)
    );

    // Two-flop synchroniser for the asynchronous board switches.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sw_meta <= '0;
            sw_sync <= '0;
        end else begin
            sw_meta <= sw_in;
            sw_sync <= sw_meta;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            wait_cnt    <= '0;
            mem_ready   <= 1'b0;
            mem_err     <= 1'b0;
            io_q        <= '0;
            rd_from_ram <= 1'b0;
        end else begin
            mem_ready <= acc_go;
            // Illegal codes error immediately; unmapped accesses error alongside mem_ready.
            mem_err   <= ((state == ST_IDLE) && !cmd_is_access(mem_cmd) && (mem_cmd != MNONE))
                         || (acc_go && unmapped);

            // Only reads move the read-data source, so read_data holds across writes.
            if (acc_rd) begin
                rd_from_ram <= hit_ram;
                if (hit_led) begin
                    io_q <= {{(DATA_W-8){1'b0}}, led_out};
                end else if (hit_sw) begin
                    io_q <= {{(DATA_W-8){1'b0}}, sw_sync};
                end else begin
                    io_q <= '0;
                end
            end

            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        if (NO_WAIT) begin
                            state <= ST_RESP;
                        end else begin
                            state    <= ST_WAIT;
                            wait_cnt <= WAIT_LOAD;
                        end
                    end
                end
                ST_WAIT: begin
                    if (wait_cnt == 4'd0) begin
                        state <= ST_RESP;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                ST_RESP: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // RAM data is already registered inside ram_sp; io_q is its I/O counterpart.
    assign read_data = rd_from_ram ? ram_q : io_q;

endmodule
